commit_retire_ctrl: RTL and testbench

//  Parametrised successor to the commit decision logic. Sits between the active-list head and the

---
 rtl/commit_retire_ctrl_pkg.sv | 84 ++++++++
 rtl/commit_insn_range.sv | 58 +++++
 rtl/commit_retire_ctrl.sv | 217 +++++++++++++++++++++
 tb/tb_commit_retire_ctrl.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/commit_retire_ctrl_pkg.sv
// Shared types for the commit/retire controller: execution states, refetch kinds,
// recovery classes, commit phases and the per-lane recovery classifier.
package commit_retire_ctrl_pkg;

    localparam int MAX_COMMIT_WIDTH = 8;

    // Wide enough for 0..MAX_COMMIT_WIDTH, so "no tail in window" can be encoded as W.
    typedef logic [3:0] lane_idx_t;
    typedef logic [3:0] lane_cnt_t;

    typedef enum logic [3:0] {
        EXEC_NOT_FINISHED          = 4'd0,
        EXEC_SUCCESS               = 4'd1,
        EXEC_REFETCH_NEXT          = 4'd2,
        EXEC_REFETCH_THIS          = 4'd3,
        EXEC_SL_FWD_MISS           = 4'd4,
        EXEC_TRAP_ECALL            = 4'd5,
        EXEC_TRAP_EBREAK           = 4'd6,
        EXEC_INSN_MISALIGNED       = 4'd7,
        EXEC_FAULT_LOAD_MISALIGNED = 4'd8,
        EXEC_FAULT_STORE_MISALIGNED= 4'd9,
        EXEC_FAULT_LOAD_ACCESS     = 4'd10,
        EXEC_FAULT_STORE_ACCESS    = 4'd11,
        EXEC_FAULT_INSN_ILLEGAL    = 4'd12,
        EXEC_FAULT_INSN_ACCESS     = 4'd13
    } exec_state_e;

    typedef enum logic [2:0] {
        RT_THIS_PC        = 3'd0,
        RT_NEXT_PC        = 3'd1,
        RT_BRANCH_TARGET  = 3'd2,
        RT_STORE_NEXT_PC  = 3'd3,
        RT_NEXT_PC_TO_CSR = 3'd4,
        RT_THIS_PC_TO_CSR = 3'd5
    } refetch_type_e;

    typedef enum logic [1:0] {
        RC_NONE = 2'd0,
        RC_HEAD = 2'd1,
        RC_TAIL = 2'd2
    } recov_class_e;

    typedef enum logic [1:0] {
        PH_COMMIT = 2'd0,
        PH_REQ    = 2'd1,
        PH_WAIT   = 2'd2
    } commit_phase_e;

    typedef struct packed {
        recov_class_e  cls;
        refetch_type_e rtype;
    } lane_class_t;

    function automatic lane_class_t classify_exec_state(exec_state_e st, logic is_branch,
                                                        logic is_store);
        lane_class_t c;
        c.cls   = RC_NONE;
        c.rtype = RT_THIS_PC;
        case (st)
            EXEC_REFETCH_NEXT: begin
                c.cls = RC_TAIL;
                if (is_branch)     c.rtype = RT_BRANCH_TARGET;
                else if (is_store) c.rtype = RT_STORE_NEXT_PC;
                else               c.rtype = RT_NEXT_PC;
            end
            EXEC_REFETCH_THIS, EXEC_SL_FWD_MISS: begin
                c.cls   = RC_HEAD;
                c.rtype = RT_THIS_PC;
            end
            EXEC_TRAP_ECALL, EXEC_TRAP_EBREAK, EXEC_INSN_MISALIGNED: begin
                c.cls   = RC_TAIL;
                c.rtype = RT_NEXT_PC_TO_CSR;
            end
            EXEC_FAULT_LOAD_MISALIGNED, EXEC_FAULT_STORE_MISALIGNED, EXEC_FAULT_LOAD_ACCESS,
            EXEC_FAULT_STORE_ACCESS, EXEC_FAULT_INSN_ILLEGAL, EXEC_FAULT_INSN_ACCESS: begin
                c.cls   = RC_HEAD;
                c.rtype = RT_THIS_PC_TO_CSR;
            end
            default: ;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/commit_insn_range.sv
// Combinational view of the active-list head window: leading finished ops, the retirable
// instruction range, and per-lane head/tail-of-instruction lane pointers.
module commit_insn_range
    import commit_retire_ctrl_pkg::*;
#(
    parameter int COMMIT_WIDTH = 4,
    parameter int AL_CNT_WIDTH = 7
) (
    input  logic [AL_CNT_WIDTH-1:0] al_valid_num_i,
    input  exec_state_e             exec_state_i [COMMIT_WIDTH],
    input  logic [COMMIT_WIDTH-1:0] last_i,
    input  logic                    step_mode_i,
    output lane_cnt_t               insn_range_o,
    output lane_idx_t               head_ptr_o [COMMIT_WIDTH],
    output lane_idx_t               tail_ptr_o [COMMIT_WIDTH]
);

    lane_cnt_t fin_ops;
    lane_idx_t cur_head;
    lane_idx_t cur_tail;

    always_comb begin
        fin_ops = '0;
        for (int i = 0; i < COMMIT_WIDTH; i++) begin
            if (int'(fin_ops) == i && int'(al_valid_num_i) > i &&
                exec_state_i[i] != EXEC_NOT_FINISHED)
                fin_ops = lane_cnt_t'(i + 1);
        end
    end

    // Step mode keeps the first instruction boundary instead of the last one.
    always_comb begin
        insn_range_o = '0;
        for (int i = 0; i < COMMIT_WIDTH; i++) begin
            if (i < int'(fin_ops) && last_i[i] && (!step_mode_i || insn_range_o == '0))
                insn_range_o = lane_cnt_t'(i + 1);
        end
    end

    always_comb begin
        cur_head = '0;
        for (int i = 0; i < COMMIT_WIDTH; i++) begin
            head_ptr_o[i] = cur_head;
            if (last_i[i])
                cur_head = lane_idx_t'(i + 1);
        end
    end

    always_comb begin
        cur_tail = lane_idx_t'(COMMIT_WIDTH);
        for (int i = COMMIT_WIDTH - 1; i >= 0; i--) begin
            if (last_i[i])
                cur_tail = lane_idx_t'(i);
            tail_ptr_o[i] = cur_tail;
        end
    end

endmodule

// File: rtl/commit_retire_ctrl.sv
// Commit decision and recovery-request sequencing for the active-list head.
// PH_COMMIT: retire | PH_REQ: hold request until ready | PH_WAIT: await recovery_done
module commit_retire_ctrl
    import commit_retire_ctrl_pkg::*;
#(
    parameter int COMMIT_WIDTH    = 4,
    parameter int AL_CNT_WIDTH    = 7,
    parameter int PC_WIDTH        = 32,
    parameter int RETIRE_CNT_W    = 64,
    parameter int DEADLOCK_CYCLES = 500,
    localparam int IDX_W = (COMMIT_WIDTH > 1) ? $clog2(COMMIT_WIDTH) : 1,
    localparam int CNT_W = $clog2(COMMIT_WIDTH + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [AL_CNT_WIDTH-1:0] al_valid_num_i,
    input  exec_state_e             head_exec_state_i [COMMIT_WIDTH],
    input  logic [COMMIT_WIDTH-1:0] head_last_i,
    input  logic [COMMIT_WIDTH-1:0] head_is_branch_i,
    input  logic [COMMIT_WIDTH-1:0] head_is_store_i,
    input  logic [COMMIT_WIDTH-1:0] head_is_load_i,
    input  logic [PC_WIDTH-1:0]     head_pc_i [COMMIT_WIDTH],
    input  logic                    step_mode_i,
    output logic                    recov_req_valid_o,
    input  logic                    recov_req_ready_i,
    output refetch_type_e           recov_req_type_o,
    output exec_state_e             recov_req_cause_o,
    output logic [IDX_W-1:0]        recov_req_index_o,
    input  logic                    recovery_done_i,
    output logic [COMMIT_WIDTH-1:0] commit_mask_o,
    output logic [CNT_W-1:0]        commit_num_o,
    output logic [CNT_W-1:0]        commit_load_num_o,
    output logic [CNT_W-1:0]        commit_store_num_o,
    output logic [PC_WIDTH-1:0]     last_commit_pc_o,
    output logic [RETIRE_CNT_W-1:0] retired_count_o,
    output logic                    deadlock_o
);

    localparam int WD_W = $clog2(DEADLOCK_CYCLES + 2);

    lane_cnt_t   insn_range;
    lane_idx_t   head_ptr   [COMMIT_WIDTH];
    lane_idx_t   tail_ptr   [COMMIT_WIDTH];
    lane_class_t lane_cls   [COMMIT_WIDTH];
    lane_idx_t   lane_point [COMMIT_WIDTH];

    commit_phase_e           phase_q, phase_d;
    logic                    valid_q, valid_d;
    refetch_type_e           type_q, type_d;
    exec_state_e             cause_q, cause_d;
    logic [IDX_W-1:0]        index_q, index_d;
    logic [PC_WIDTH-1:0]     pc_q, pc_d;
    logic [RETIRE_CNT_W-1:0] retired_q, retired_d;
    logic [WD_W-1:0]         wd_q, wd_d;
    logic                    dead_q, dead_d;

    logic                    trig;
    lane_idx_t               win_lane;
    lane_idx_t               win_point;
    logic                    win_tail;
    refetch_type_e           win_type;
    exec_state_e             win_cause;
    logic [COMMIT_WIDTH-1:0] mask;
    lane_cnt_t               n_commit, n_load, n_store, n_insn;

    commit_insn_range #(
        .COMMIT_WIDTH (COMMIT_WIDTH),
        .AL_CNT_WIDTH (AL_CNT_WIDTH)
    ) u_insn_range (
        .al_valid_num_i (al_valid_num_i),
        .exec_state_i   (head_exec_state_i),
        .last_i         (head_last_i),
        .step_mode_i    (step_mode_i),
        .insn_range_o   (insn_range),
        .head_ptr_o     (head_ptr),
        .tail_ptr_o     (tail_ptr)
    );

    always_comb begin
        for (int i = 0; i < COMMIT_WIDTH; i++) begin
            lane_cls[i]   = classify_exec_state(head_exec_state_i[i], head_is_branch_i[i],
                                                head_is_store_i[i]);
            lane_point[i] = (lane_cls[i].cls == RC_HEAD) ? head_ptr[i] : tail_ptr[i];
        end
    end

    // Earliest recovery point wins; strict compare leaves ties with the lower lane.
    always_comb begin
        trig      = 1'b0;
        win_lane  = '0;
        win_point = '0;
        win_tail  = 1'b0;
        win_type  = RT_THIS_PC;
        win_cause = EXEC_SUCCESS;
        for (int i = 0; i < COMMIT_WIDTH; i++) begin
            if (i < int'(insn_range) && lane_cls[i].cls != RC_NONE &&
                (!trig || lane_point[i] < win_point)) begin
                trig      = 1'b1;
                win_lane  = lane_idx_t'(i);
                win_point = lane_point[i];
                win_tail  = (lane_cls[i].cls == RC_TAIL);
                win_type  = lane_cls[i].rtype;
                win_cause = head_exec_state_i[i];
            end
        end
    end

    always_comb begin
        mask = '0;
        if (phase_q == PH_COMMIT) begin
            for (int i = 0; i < COMMIT_WIDTH; i++) begin
                if (trig)
                    mask[i] = (i < int'(win_point)) || (i == int'(win_point) && win_tail);
                else
                    mask[i] = (i < int'(insn_range));
            end
        end
    end

    always_comb begin
        n_commit = '0;
        n_load   = '0;
        n_store  = '0;
        n_insn   = '0;
        pc_d     = pc_q;
        for (int i = 0; i < COMMIT_WIDTH; i++) begin
            n_commit = n_commit + lane_cnt_t'(mask[i]);
            n_load   = n_load   + lane_cnt_t'(mask[i] & head_is_load_i[i]);
            n_store  = n_store  + lane_cnt_t'(mask[i] & head_is_store_i[i]);
            n_insn   = n_insn   + lane_cnt_t'(mask[i] & head_last_i[i]);
            if (mask[i])
                pc_d = head_pc_i[i];
        end
        retired_d = retired_q + RETIRE_CNT_W'(n_insn);
    end

    always_comb begin
        wd_d = wd_q;
        if (mask != '0 || phase_q == PH_WAIT)
            wd_d = '0;
        else if (wd_q != '1)
            wd_d = wd_q + 1'b1;
        dead_d = dead_q;
        if (DEADLOCK_CYCLES > 0 && int'(wd_d) > DEADLOCK_CYCLES)
            dead_d = 1'b1;
    end

    always_comb begin
        phase_d = phase_q;
        valid_d = valid_q;
        type_d  = type_q;
        cause_d = cause_q;
        index_d = index_q;
        case (phase_q)
            PH_COMMIT: begin
                if (trig) begin
                    phase_d = PH_REQ;
                    valid_d = 1'b1;
                    type_d  = win_type;
                    cause_d = win_cause;
                    index_d = IDX_W'(win_lane);
                end
            end
            PH_REQ: begin
                if (valid_q && recov_req_ready_i) begin
                    phase_d = PH_WAIT;
                    valid_d = 1'b0;
                end
            end
            PH_WAIT: begin
                if (recovery_done_i)
                    phase_d = PH_COMMIT;
            end
            default: begin
                phase_d = PH_COMMIT;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q   <= PH_COMMIT;
            valid_q   <= 1'b0;
            type_q    <= RT_THIS_PC;
            cause_q   <= EXEC_SUCCESS;
            index_q   <= '0;
            pc_q      <= '0;
            retired_q <= '0;
            wd_q      <= '0;
            dead_q    <= 1'b0;
        end else begin
            phase_q   <= phase_d;
            valid_q   <= valid_d;
            type_q    <= type_d;
            cause_q   <= cause_d;
            index_q   <= index_d;
            pc_q      <= pc_d;
            retired_q <= retired_d;
            wd_q      <= wd_d;
            dead_q    <= dead_d;
        end
    end

    assign commit_mask_o      = mask;
    assign commit_num_o       = CNT_W'(n_commit);
    assign commit_load_num_o  = CNT_W'(n_load);
    assign commit_store_num_o = CNT_W'(n_store);
    assign recov_req_valid_o  = valid_q;
    assign recov_req_type_o   = type_q;
    assign recov_req_cause_o  = cause_q;
    assign recov_req_index_o  = index_q;
    assign last_commit_pc_o   = pc_q;
    assign retired_count_o    = retired_q;
    assign deadlock_o         = dead_q;

endmodule

// File: tb/tb_commit_retire_ctrl.sv
// Bench for commit_retire_ctrl: directed scenarios plus randomized traffic against a
// rule-level reference model of retirement, recovery handshake and watchdog.
module tb_commit_retire_ctrl;
    import commit_retire_ctrl_pkg::*;

    localparam int W   = 4;
    localparam int DLC = 10;
    localparam int M_COMMIT = 0, M_REQ = 1, M_WAIT = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic [6:0]    al;
    exec_state_e   st [W];
    logic [W-1:0]  last, br, sto, ld;
    logic [31:0]   pc [W];
    logic          step, ready, done;
    logic          valid_o;
    refetch_type_e type_o;
    exec_state_e   cause_o;
    logic [1:0]    index_o;
    logic [W-1:0]  mask_o;
    logic [2:0]    num_o, lnum_o, snum_o;
    logic [31:0]   lpc_o;
    logic [63:0]   rcnt_o;
    logic          dl_o;

    int n_cmp  = 0;
    int n_fail = 0;

    int            m_phase, m_index, m_idle;
    refetch_type_e m_type;
    exec_state_e   m_cause;
    logic [31:0]   m_pc;
    logic [63:0]   m_retired;
    bit            m_dead;
    logic [W-1:0]  e_mask;
    bit            e_trig, e_tail;
    int            e_lane;
    refetch_type_e e_type;
    exec_state_e   e_cause;

    commit_retire_ctrl #(.COMMIT_WIDTH(W), .AL_CNT_WIDTH(7), .PC_WIDTH(32),
                         .RETIRE_CNT_W(64), .DEADLOCK_CYCLES(DLC)) dut (
        .clk(clk), .rst(rst), .al_valid_num_i(al), .head_exec_state_i(st),
        .head_last_i(last), .head_is_branch_i(br), .head_is_store_i(sto),
        .head_is_load_i(ld), .head_pc_i(pc), .step_mode_i(step),
        .recov_req_valid_o(valid_o), .recov_req_ready_i(ready), .recov_req_type_o(type_o),
        .recov_req_cause_o(cause_o), .recov_req_index_o(index_o),
        .recovery_done_i(done), .commit_mask_o(mask_o), .commit_num_o(num_o),
        .commit_load_num_o(lnum_o), .commit_store_num_o(snum_o),
        .last_commit_pc_o(lpc_o), .retired_count_o(rcnt_o), .deadlock_o(dl_o)
    );

    always #5 clk = ~clk;

    // 0: no recovery, 1: recover at head of insn, 2: recover after tail of insn
    function automatic int m_kind(exec_state_e s);
        case (s)
            EXEC_REFETCH_NEXT, EXEC_TRAP_ECALL, EXEC_TRAP_EBREAK, EXEC_INSN_MISALIGNED: return 2;
            EXEC_REFETCH_THIS, EXEC_SL_FWD_MISS, EXEC_FAULT_LOAD_MISALIGNED,
            EXEC_FAULT_STORE_MISALIGNED, EXEC_FAULT_LOAD_ACCESS, EXEC_FAULT_STORE_ACCESS,
            EXEC_FAULT_INSN_ILLEGAL, EXEC_FAULT_INSN_ACCESS: return 1;
            default: return 0;
        endcase
    endfunction

    function automatic refetch_type_e m_rtype(exec_state_e s, logic b, logic t);
        if (s == EXEC_REFETCH_NEXT) begin
            if (b) return RT_BRANCH_TARGET;
            if (t) return RT_STORE_NEXT_PC;
            return RT_NEXT_PC;
        end
        if (s == EXEC_REFETCH_THIS || s == EXEC_SL_FWD_MISS) return RT_THIS_PC;
        if (m_kind(s) == 2) return RT_NEXT_PC_TO_CSR;
        return RT_THIS_PC_TO_CSR;
    endfunction

    function automatic void model_comb();
        int fin, rng, best, pt, k;
        e_mask = '0; e_trig = 0; e_tail = 0; e_lane = 0;
        e_type = RT_THIS_PC; e_cause = EXEC_SUCCESS;
        if (m_phase != M_COMMIT) return;
        fin = 0;
        while (fin < W && fin < int'(al) && st[fin] != EXEC_NOT_FINISHED) fin++;
        rng = 0;
        for (int i = 0; i < fin; i++)
            if (last[i] && !(step && rng != 0)) rng = i + 1;
        best = W + 1;
        for (int i = 0; i < rng; i++) begin
            k = m_kind(st[i]);
            if (k != 0) begin
                pt = i;
                if (k == 1) while (pt > 0 && !last[pt-1]) pt--;
                else        while (pt < W - 1 && !last[pt]) pt++;
                if (pt < best) begin
                    best = pt; e_trig = 1; e_lane = i; e_tail = (k == 2);
                    e_type = m_rtype(st[i], br[i], sto[i]); e_cause = st[i];
                end
            end
        end
        for (int i = 0; i < W; i++)
            e_mask[i] = e_trig ? (i < best || (i == best && e_tail)) : (i < rng);
    endfunction

    function automatic void model_seq();
        m_retired += 64'($countones(e_mask & last));
        for (int i = 0; i < W; i++) if (e_mask[i]) m_pc = pc[i];
        if (e_mask != '0 || m_phase == M_WAIT) m_idle = 0;
        else m_idle++;
        if (m_idle > DLC) m_dead = 1;
        case (m_phase)
            M_COMMIT: if (e_trig) begin
                m_phase = M_REQ; m_type = e_type; m_cause = e_cause; m_index = e_lane;
            end
            M_REQ:    if (ready) m_phase = M_WAIT;
            default:  if (done) m_phase = M_COMMIT;
        endcase
    endfunction

    function automatic void model_reset();
        m_phase = M_COMMIT; m_type = RT_THIS_PC; m_cause = EXEC_SUCCESS; m_index = 0;
        m_pc = '0; m_retired = '0; m_idle = 0; m_dead = 0;
    endfunction

    task automatic tick();
        model_comb();
        @(posedge clk);
        model_seq();
        #1;
    endtask

    task automatic set_uniform(exec_state_e s, logic [W-1:0] l);
        for (int i = 0; i < W; i++) begin
            st[i] = s;
            pc[i] = 32'h1000 + 32'(4 * i);
        end
        last = l; br = '0; sto = '0; ld = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1; al = '0; step = 0; ready = 0; done = 0;
        set_uniform(EXEC_SUCCESS, '1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        n_cmp++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", valid_o); end
        n_cmp++; if (type_o !== RT_THIS_PC) begin n_fail++; $display("FAIL reset_type: got %0d want %0d", type_o, RT_THIS_PC); end
        n_cmp++; if (cause_o !== EXEC_SUCCESS) begin n_fail++; $display("FAIL reset_cause: got %0d want %0d", cause_o, EXEC_SUCCESS); end
        n_cmp++; if (index_o !== 2'd0) begin n_fail++; $display("FAIL reset_index: got %0d want 0", index_o); end
        n_cmp++; if (lpc_o !== 32'd0 || rcnt_o !== 64'd0 || dl_o !== 1'b0) begin
            n_fail++; $display("FAIL reset_counters: got pc=%0h cnt=%0d dl=%b want 0/0/0", lpc_o, rcnt_o, dl_o); end
        n_cmp++; if (mask_o !== 4'b0000) begin n_fail++; $display("FAIL al_zero_mask: got %b want 0000", mask_o); end
    endtask

    task automatic test_full_commit();
        do_reset();
        al = 7'd4; ld = 4'b0011; sto = 4'b0100;
        #1;
        n_cmp++; if (mask_o !== 4'b1111) begin n_fail++; $display("FAIL full_mask: got %b want 1111", mask_o); end
        n_cmp++; if (num_o !== 3'd4 || lnum_o !== 3'd2 || snum_o !== 3'd1) begin
            n_fail++; $display("FAIL full_nums: got %0d/%0d/%0d want 4/2/1", num_o, lnum_o, snum_o); end
        tick();
        al = '0;
        #1;
        n_cmp++; if (rcnt_o !== 64'd4) begin n_fail++; $display("FAIL full_retired: got %0d want 4", rcnt_o); end
        n_cmp++; if (lpc_o !== 32'h100c) begin n_fail++; $display("FAIL full_last_pc: got %0h want 100c", lpc_o); end
    endtask

    task automatic test_partial();
        do_reset();
        al = 7'd4; st[2] = EXEC_NOT_FINISHED; last = 4'b1010;
        #1;
        n_cmp++; if (mask_o !== 4'b0011) begin n_fail++; $display("FAIL partial_mask: got %b want 0011", mask_o); end
        tick();
        n_cmp++; if (rcnt_o !== 64'd1 || lpc_o !== 32'h1004) begin
            n_fail++; $display("FAIL partial_counts: got cnt=%0d pc=%0h want 1/1004", rcnt_o, lpc_o); end
        al = 7'd9; set_uniform(EXEC_SUCCESS, 4'b1000);
        #1;
        n_cmp++; if (mask_o !== 4'b1111) begin n_fail++; $display("FAIL al_over_w_mask: got %b want 1111", mask_o); end
    endtask

    task automatic test_refetch_branch();
        do_reset();
        al = 7'd4; st[1] = EXEC_REFETCH_NEXT; br[1] = 1'b1;
        #1;
        n_cmp++; if (mask_o !== 4'b0011) begin n_fail++; $display("FAIL refetch_mask: got %b want 0011", mask_o); end
        tick();
        n_cmp++; if (valid_o !== 1'b1 || type_o !== RT_BRANCH_TARGET || index_o !== 2'd1 || cause_o !== EXEC_REFETCH_NEXT) begin
            n_fail++; $display("FAIL refetch_req: got v=%b t=%0d i=%0d c=%0d want 1/%0d/1/%0d",
                               valid_o, type_o, index_o, cause_o, RT_BRANCH_TARGET, EXEC_REFETCH_NEXT); end
        n_cmp++; if (mask_o !== 4'b0000) begin n_fail++; $display("FAIL refetch_req_mask: got %b want 0000", mask_o); end
    endtask

    task automatic test_fault_handshake();
        do_reset();
        al = 7'd4; st[1] = EXEC_FAULT_LOAD_MISALIGNED;
        #1;
        n_cmp++; if (mask_o !== 4'b0001) begin n_fail++; $display("FAIL fault_mask: got %b want 0001", mask_o); end
        tick();
        for (int c = 0; c < 3; c++) begin
            #1;
            n_cmp++; if (valid_o !== 1'b1 || type_o !== RT_THIS_PC_TO_CSR || index_o !== 2'd1 ||
                         cause_o !== EXEC_FAULT_LOAD_MISALIGNED || mask_o !== 4'b0000) begin
                n_fail++; $display("FAIL fault_hold: cyc %0d got v=%b t=%0d i=%0d c=%0d m=%b", c,
                                   valid_o, type_o, index_o, cause_o, mask_o); end
            tick();
        end
        ready = 1'b1;
        tick();
        ready = 1'b0; set_uniform(EXEC_SUCCESS, '1);
        #1;
        n_cmp++; if (valid_o !== 1'b0 || mask_o !== 4'b0000) begin
            n_fail++; $display("FAIL fault_wait: got v=%b m=%b want 0/0000", valid_o, mask_o); end
        tick();
        done = 1'b1;
        tick();
        done = 1'b0;
        #1;
        n_cmp++; if (mask_o !== 4'b1111) begin n_fail++; $display("FAIL fault_resume: got %b want 1111", mask_o); end
    endtask

    task automatic test_step_mode();
        do_reset();
        step = 1'b1;
        for (int c = 0; c < 4; c++) begin
            al = 7'(4 - c);
            #1;
            n_cmp++; if (mask_o !== 4'b0001) begin n_fail++; $display("FAIL step_mask: cyc %0d got %b want 0001", c, mask_o); end
            tick();
        end
        al = '0;
        #1;
        n_cmp++; if (rcnt_o !== 64'd4 || mask_o !== 4'b0000) begin
            n_fail++; $display("FAIL step_drain: got cnt=%0d m=%b want 4/0000", rcnt_o, mask_o); end
    endtask

    task automatic test_deadlock();
        do_reset();
        al = 7'd4; st[0] = EXEC_NOT_FINISHED;
        repeat (DLC) tick();
        n_cmp++; if (dl_o !== 1'b0) begin n_fail++; $display("FAIL deadlock_early: got %b want 0", dl_o); end
        tick();
        n_cmp++; if (dl_o !== 1'b1) begin n_fail++; $display("FAIL deadlock_set: got %b want 1", dl_o); end
        st[0] = EXEC_SUCCESS;
        tick();
        n_cmp++; if (dl_o !== 1'b1 || rcnt_o !== 64'd4) begin
            n_fail++; $display("FAIL deadlock_sticky: got dl=%b cnt=%0d want 1/4", dl_o, rcnt_o); end
        do_reset();
        n_cmp++; if (dl_o !== 1'b0) begin n_fail++; $display("FAIL deadlock_rst: got %b want 0", dl_o); end
    endtask

    task automatic test_rst_mid_req();
        do_reset();
        al = 7'd4; st[2] = EXEC_FAULT_STORE_ACCESS;
        #1;
        n_cmp++; if (mask_o !== 4'b0011) begin n_fail++; $display("FAIL midreq_mask: got %b want 0011", mask_o); end
        tick();
        #1;
        rst = 1'b1;
        #1;
        n_cmp++; if (valid_o !== 1'b0 || cause_o !== EXEC_SUCCESS) begin
            n_fail++; $display("FAIL midreq_async: got v=%b c=%0d want 0/%0d", valid_o, cause_o, EXEC_SUCCESS); end
        rst = 1'b0; model_reset();
        st[2] = EXEC_SUCCESS;
        #1;
        n_cmp++; if (mask_o !== 4'b1111) begin n_fail++; $display("FAIL midreq_commit: got %b want 1111", mask_o); end
        tick();
    endtask

    task automatic test_random();
        int r;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            if (c == 200) do_reset();
            al = 7'($urandom_range(0, 6));
            for (int i = 0; i < W; i++) begin
                r = $urandom_range(0, 15);
                if (r < 9)       st[i] = EXEC_SUCCESS;
                else if (r < 11) st[i] = EXEC_NOT_FINISHED;
                else             st[i] = exec_state_e'(4'($urandom_range(2, 13)));
                pc[i] = $urandom;
            end
            last = 4'($urandom); br = 4'($urandom); sto = 4'($urandom); ld = 4'($urandom);
            step  = ($urandom_range(0, 7) == 0);
            ready = ($urandom_range(0, 2) == 0);
            done  = ($urandom_range(0, 3) == 0);
            #1;
            model_comb();
            n_cmp++; if (mask_o !== e_mask) begin n_fail++; $display("FAIL rnd_mask: cyc %0d got %b want %b", c, mask_o, e_mask); end
            n_cmp++; if (num_o !== 3'($countones(e_mask)) || lnum_o !== 3'($countones(e_mask & ld)) ||
                         snum_o !== 3'($countones(e_mask & sto))) begin
                n_fail++; $display("FAIL rnd_nums: cyc %0d got %0d/%0d/%0d want %0d/%0d/%0d", c, num_o, lnum_o,
                                   snum_o, $countones(e_mask), $countones(e_mask & ld), $countones(e_mask & sto)); end
            n_cmp++; if (valid_o !== (m_phase == M_REQ)) begin
                n_fail++; $display("FAIL rnd_valid: cyc %0d got %b want %b", c, valid_o, m_phase == M_REQ); end
            n_cmp++; if (type_o !== m_type || cause_o !== m_cause || index_o !== 2'(m_index)) begin
                n_fail++; $display("FAIL rnd_payload: cyc %0d got %0d/%0d/%0d want %0d/%0d/%0d", c, type_o, cause_o,
                                   index_o, m_type, m_cause, m_index); end
            n_cmp++; if (lpc_o !== m_pc || rcnt_o !== m_retired) begin
                n_fail++; $display("FAIL rnd_counters: cyc %0d got pc=%0h cnt=%0d want %0h/%0d", c, lpc_o, rcnt_o,
                                   m_pc, m_retired); end
            n_cmp++; if (dl_o !== m_dead) begin n_fail++; $display("FAIL rnd_deadlock: cyc %0d got %b want %b", c, dl_o, m_dead); end
            tick();
        end
    endtask

    initial begin
        rst = 1'b1;
        test_reset();
        test_full_commit();
        test_partial();
        test_refetch_branch();
        test_fault_handshake();
        test_step_mode();
        test_deadlock();
        test_rst_mid_req();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
